// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - shared types, padding constants and byte-swap helpers for sha256d_nonce_ctrl
package sha2_pkg;

  localparam int HDR_W = 640;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_PREP,
    S_P1_RUN,
    S_P2_PREP,
    S_P2_RUN,
    S_CHECK
  } state_e;

  // Message bit-lengths placed in the final 64 bits of the last chunk
  localparam logic [63:0] LEN640 = 64'd640;
  localparam logic [63:0] LEN256 = 64'd256;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = x[8*(31-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256d_pad.sv
// rtl/sha256d_pad.sv - combinational message builder for the two sha256d passes
module sha256d_pad
  import sha2_pkg::*;
(
  input  logic                pass2_i,
  input  logic [HDR_W-33:0]   hdr_i,
  input  logic [31:0]         nonce_i,
  input  logic [255:0]        hash1_i,
  output logic [1023:0]       str_o,
  output logic [1:0]          num_chunks_o
);

  // Header nonce field is little-endian on the wire, hence the swap
  always_comb begin
    if (pass2_i) begin
      str_o        = {hash1_i, 1'b1, 191'b0, LEN256, 512'b0};
      num_chunks_o = 2'd1;
    end else begin
      str_o        = {hdr_i, bswap32(nonce_i), 1'b1, 319'b0, LEN640};
      num_chunks_o = 2'd2;
    end
  end

endmodule

// File: rtl/sha256d_nonce_ctrl.sv
// rtl/sha256d_nonce_ctrl.sv - nonce-iterating double-SHA-256 job controller around one sha256 core
module sha256d_nonce_ctrl
  import sha2_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_start,
  input  logic              abort,
  input  logic [HDR_W-1:0]  header_in,
  input  logic [255:0]      target,
  input  logic [31:0]       nonce_start,
  input  logic [31:0]       nonce_end,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic [31:0]       found_nonce,
  output logic [255:0]      found_hash,
  output logic [CNT_W-1:0]  hashes_done,
  output logic              core_reset,
  output logic              core_start,
  output logic [1:0]        core_num_chunks,
  output logic [1023:0]     core_str,
  input  logic              core_done,
  input  logic [255:0]      core_hash
);

  state_e              state_q, state_d;
  logic [HDR_W-33:0]   hdr_q, hdr_d;
  logic [255:0]        target_q, target_d;
  logic [31:0]         nonce_end_q, nonce_end_d;
  logic [31:0]         nonce_q, nonce_d;
  logic [255:0]        hash1_q, hash1_d;
  logic [255:0]        hash2_q, hash2_d;
  logic [31:0]         found_nonce_q, found_nonce_d;
  logic [255:0]        found_hash_q, found_hash_d;
  logic [CNT_W-1:0]    hashes_done_q, hashes_done_d;
  logic                found_q, found_d;
  logic                exhausted_q, exhausted_d;
  logic [255:0]        val;
  logic                pass2;
  logic                unused_nonce_field;

  // The incoming nonce field is always replaced by the iterated nonce
  assign unused_nonce_field = ^header_in[31:0];

  assign val   = bswap256(hash2_q);
  assign pass2 = (state_q == S_P2_PREP) || (state_q == S_P2_RUN);

  sha256d_pad u_pad (
    .pass2_i      (pass2),
    .hdr_i        (hdr_q),
    .nonce_i      (nonce_q),
    .hash1_i      (hash1_q),
    .str_o        (core_str),
    .num_chunks_o (core_num_chunks)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hdr_q         <= '0;
      target_q      <= '0;
      nonce_end_q   <= '0;
      nonce_q       <= '0;
      hash1_q       <= '0;
      hash2_q       <= '0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      hashes_done_q <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      target_q      <= target_d;
      nonce_end_q   <= nonce_end_d;
      nonce_q       <= nonce_d;
      hash1_q       <= hash1_d;
      hash2_q       <= hash2_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      hashes_done_q <= hashes_done_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    target_d      = target_q;
    nonce_end_d   = nonce_end_q;
    nonce_d       = nonce_q;
    hash1_d       = hash1_q;
    hash2_d       = hash2_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    hashes_done_d = hashes_done_q;
    found_d       = 1'b0;
    exhausted_d   = 1'b0;

    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_start && !abort) begin
            hdr_d         = header_in[HDR_W-1:32];
            target_d      = target;
            nonce_end_d   = nonce_end;
            nonce_d       = nonce_start;
            hashes_done_d = '0;
            state_d       = S_P1_PREP;
          end
        end
        S_P1_PREP: state_d = S_P1_RUN;
        S_P1_RUN: begin
          if (core_done) begin
            hash1_d = core_hash;
            state_d = S_P2_PREP;
          end
        end
        S_P2_PREP: state_d = S_P2_RUN;
        S_P2_RUN: begin
          if (core_done) begin
            hash2_d = core_hash;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (hashes_done_q != {CNT_W{1'b1}}) begin
            hashes_done_d = hashes_done_q + CNT_W'(1);
          end
          // A hit wins over exhaustion when both occur on the last nonce
          if (val <= target_q) begin
            found_d       = 1'b1;
            found_nonce_d = nonce_q;
            found_hash_d  = val;
            state_d       = S_IDLE;
          end else if (nonce_q == nonce_end_q) begin
            exhausted_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = S_P1_PREP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The core's chunk counter clears only on reset, so each pass starts from a reset cycle
  assign core_reset  = (state_q == S_IDLE) || (state_q == S_P1_PREP) || (state_q == S_P2_PREP);
  assign core_start  = (state_q == S_P1_RUN) || (state_q == S_P2_RUN);
  assign busy        = (state_q != S_IDLE);
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign hashes_done = hashes_done_q;

endmodule

// File: tb/tb_sha256d_nonce_ctrl.sv
// tb/tb_sha256d_nonce_ctrl.sv - directed vector bench with a behavioural sha256 core
module tb_sha256d_nonce_ctrl;

  logic           clk = 1'b0;
  logic           rst;
  logic           job_start, abort;
  logic [639:0]   header_in;
  logic [255:0]   target;
  logic [31:0]    nonce_start, nonce_end;
  logic           busy, found, exhausted;
  logic [31:0]    found_nonce;
  logic [255:0]   found_hash;
  logic [31:0]    hashes_done;
  logic           core_reset, core_start;
  logic [1:0]     core_num_chunks;
  logic [1023:0]  core_str;
  logic           core_done;
  logic [255:0]   core_hash;

  int total = 0;
  int bad = 0;

  sha256d_nonce_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(rst), .job_start(job_start), .abort(abort),
    .header_in(header_in), .target(target), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .busy(busy), .found(found), .exhausted(exhausted), .found_nonce(found_nonce),
    .found_hash(found_hash), .hashes_done(hashes_done), .core_reset(core_reset),
    .core_start(core_start), .core_num_chunks(core_num_chunks), .core_str(core_str),
    .core_done(core_done), .core_hash(core_hash)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [255:0] sha_msg(input logic [1023:0] s, input logic [1:0] n);
    logic [255:0] hh;
    hh = compress(IV, s[1023:512]);
    if (n == 2'd2) hh = compress(hh, s[511:0]);
    return hh;
  endfunction

  function automatic logic [255:0] rev256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  // Independent reference for the byte-reversed double hash of a header with a given nonce
  function automatic logic [255:0] ref_dhash(input logic [639:0] hdr, input logic [31:0] n);
    logic [1023:0] m;
    logic [255:0]  h1;
    m  = {hdr[639:32], n[7:0], n[15:8], n[23:16], n[31:24], 1'b1, 319'b0, 64'd640};
    h1 = sha_msg(m, 2'd2);
    m  = {h1, 1'b1, 191'b0, 64'd256, 512'b0};
    return rev256(sha_msg(m, 2'd1));
  endfunction

  // Behavioural core: one run per reset, done after a fixed per-chunk latency
  logic         cm_busy, cm_used;
  int           cm_cnt;
  logic [255:0] cm_res;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_reset) begin
      cm_busy <= 1'b0;
      cm_used <= 1'b0;
    end else if (cm_busy) begin
      if (cm_cnt == 0) begin
        core_done <= 1'b1;
        core_hash <= cm_res;
        cm_busy   <= 1'b0;
        cm_used   <= 1'b1;
      end else begin
        cm_cnt <= cm_cnt - 1;
      end
    end else if (core_start && !cm_used) begin
      cm_res  <= sha_msg(core_str, core_num_chunks);
      cm_busy <= 1'b1;
      cm_cnt  <= 8 * int'(core_num_chunks);
    end
  end

  int          found_cnt, exh_cnt, rises, rs_bad;
  logic        prev_start = 1'b0, prev_reset = 1'b1;
  logic [31:0] nonce_log [$];
  always @(negedge clk) begin
    if (core_start && !prev_start) begin
      rises++;
      if (!prev_reset) rs_bad++;
      if (core_num_chunks == 2'd2)
        nonce_log.push_back({core_str[391:384], core_str[399:392], core_str[407:400], core_str[415:408]});
    end
    if (core_start && core_reset) rs_bad++;
    if (found) found_cnt++;
    if (exhausted) exh_cnt++;
    prev_start = core_start;
    prev_reset = core_reset;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    found_cnt = 0; exh_cnt = 0; rises = 0; rs_bad = 0;
    nonce_log.delete();
  endtask

  task automatic start_job(input logic [639:0] h, input logic [255:0] t, input logic [31:0] ns,
                           input logic [31:0] ne);
    @(negedge clk);
    header_in = h; target = t; nonce_start = ns; nonce_end = ne; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic wait_end(output bit gf, output bit ge);
    gf = 0; ge = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (found) begin gf = 1; break; end
      if (exhausted) begin ge = 1; break; end
    end
  endtask

  typedef struct {
    string         name;
    logic [639:0]  hdr;
    logic [255:0]  tgt;
    logic [31:0]   ns, ne;
    bit            exp_found;
    logic [31:0]   exp_nonce;
    logic [255:0]  exp_hash;
    int            exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit gf, ge;
    clear_mon();
    start_job(v.hdr, v.tgt, v.ns, v.ne);
    chk({v.name, "_busy"}, busy, 1'b1);
    wait_end(gf, ge);
    chk({v.name, "_ended"}, gf | ge, 1'b1);
    chk({v.name, "_found"}, found, v.exp_found);
    chk({v.name, "_exhausted"}, exhausted, !v.exp_found);
    chk({v.name, "_nonce"}, found_nonce, v.exp_nonce);
    chk({v.name, "_hash"}, found_hash, v.exp_hash);
    chk({v.name, "_hashes_done"}, hashes_done, v.exp_done);
    @(negedge clk);
    chk({v.name, "_busy_after"}, busy, 1'b0);
    chk({v.name, "_pulse_width"}, found | exhausted, 1'b0);
    chk({v.name, "_found_cnt"}, found_cnt, v.exp_found ? 1 : 0);
    chk({v.name, "_exh_cnt"}, exh_cnt, v.exp_found ? 0 : 1);
    chk({v.name, "_rst_before_start"}, rs_bad, 0);
    chk({v.name, "_start_rises"}, rises, 2 * v.exp_done);
  endtask

  localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h00000000};
  localparam logic [255:0] GEN_TGT  = {32'h0, 16'hffff, 208'h0};
  localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  vec_t vecs [4];
  logic [255:0] ones_hash;
  bit gf, ge;

  initial begin
    rst = 1'b1; job_start = 1'b0; abort = 1'b0;
    header_in = '0; target = '0; nonce_start = '0; nonce_end = '0;
    ones_hash = ref_dhash(GEN_HDR ^ {640{1'b1}} >> 8, 32'h12345678);

    vecs[0] = '{"genesis", GEN_HDR, GEN_TGT, 32'h7c2bac1b, 32'h7c2bac20, 1'b1, 32'h7c2bac1d, GEN_HASH, 3};
    vecs[1] = '{"exhaust", GEN_HDR, GEN_TGT, 32'h7c2bac1b, 32'h7c2bac1c, 1'b0, 32'h7c2bac1d, GEN_HASH, 2};
    vecs[2] = '{"wrap", GEN_HDR, 256'h0, 32'hffffffff, 32'h00000001, 1'b0, 32'h7c2bac1d, GEN_HASH, 3};
    vecs[3] = '{"ones", GEN_HDR ^ {640{1'b1}} >> 8, {256{1'b1}}, 32'h12345678, 32'h12345690,
                1'b1, 32'h12345678, ones_hash, 1};

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_found", {found, exhausted}, 2'b00);
    chk("rst_found_nonce", found_nonce, 32'h0);
    chk("rst_found_hash", found_hash, 256'h0);
    chk("rst_hashes_done", hashes_done, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
      if (i == 2) begin
        chk("wrap_log_len", nonce_log.size(), 3);
        if (nonce_log.size() == 3) begin
          chk("wrap_n0", nonce_log[0], 32'hffffffff);
          chk("wrap_n1", nonce_log[1], 32'h00000000);
          chk("wrap_n2", nonce_log[2], 32'h00000001);
        end
      end
    end

    // Abort during the second pass of the first nonce
    clear_mon();
    start_job(GEN_HDR, GEN_TGT, 32'h7c2bac1b, 32'h7c2bac20);
    for (int c = 0; c < 500; c++) begin
      if (core_start && core_num_chunks == 2'd1) break;
      @(negedge clk);
    end
    chk("abort_reached_p2", {core_start, core_num_chunks}, 3'b101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_core_start", core_start, 1'b0);
    repeat (40) @(negedge clk);
    chk("abort_pulses", found_cnt + exh_cnt, 0);
    chk("abort_hashes_done", hashes_done, 32'h0);
    chk("abort_found_nonce", found_nonce, 32'h12345678);
    chk("abort_found_hash", found_hash, ones_hash);
    run_vec(vecs[0]);

    // job_start with abort in IDLE is not accepted
    @(negedge clk);
    job_start = 1'b1; abort = 1'b1;
    @(negedge clk);
    job_start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    @(negedge clk);
    chk("start_abort_busy2", busy, 1'b0);

    // A second job_start while busy must not disturb the running job
    clear_mon();
    start_job(GEN_HDR, GEN_TGT, 32'h7c2bac1b, 32'h7c2bac20);
    repeat (5) @(negedge clk);
    header_in = '0; target = {256{1'b1}}; nonce_start = 32'h0; nonce_end = 32'h0; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    wait_end(gf, ge);
    chk("busy_start_found", {gf, ge}, 2'b10);
    chk("busy_start_nonce", found_nonce, 32'h7c2bac1d);
    chk("busy_start_hashes", hashes_done, 32'd3);

    // Asynchronous reset between edges during pass 1
    start_job(GEN_HDR, GEN_TGT, 32'h7c2bac1b, 32'h7c2bac20);
    for (int c = 0; c < 500; c++) begin
      if (core_start && core_num_chunks == 2'd2) break;
      @(negedge clk);
    end
    chk("areset_reached_p1", {core_start, core_num_chunks}, 3'b110);
    #2 rst = 1'b1;
    #1;
    chk("areset_busy", busy, 1'b0);
    chk("areset_core_reset", core_reset, 1'b1);
    chk("areset_core_start", core_start, 1'b0);
    chk("areset_found_nonce", found_nonce, 32'h0);
    chk("areset_found_hash", found_hash, 256'h0);
    chk("areset_hashes_done", hashes_done, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256d_nonce_ctrl.md
Name: sha256d_nonce_ctrl

Overview:
- Upstream/downstream controller wrapped around one sha256 core instantiated with MAX_CHUNKS=2.
- Per job: iterates the 32-bit nonce over an 80-byte block header and pads the header into a 2-chunk message for pass 1.
- Re-pads the pass-1 digest into a 1-chunk message for pass 2 (double SHA-256), then compares the result against a target.
- Reports the first hit, or exhaustion of the nonce range.

Parameters:
- HDR_W, 640, header width in bits (fixed by the protocol; exposed for the package only).
- CNT_W, 32, width of hashes_done counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- job_start  in  1  one-cycle pulse; latches header_in, target, nonce_start, nonce_end
- abort  in  1  abandon current job
- header_in  in  640  header, big-endian byte order; bits [31:0] are the nonce field (overwritten)
- target  in  256  unsigned threshold
- nonce_start  in  32  first nonce tried
- nonce_end  in  32  last nonce tried (inclusive)
- busy  out  1  high from the cycle after an accepted job_start until the job finishes
- found  out  1  one-cycle pulse on hit
- exhausted  out  1  one-cycle pulse when nonce_end was checked without a hit
- found_nonce  out  32  nonce of the hit, held until the next accepted job_start
- found_hash  out  256  byte-reversed final digest of the hit, held likewise
- hashes_done  out  CNT_W  nonces checked in the current job
- core_reset  out  1  to sha256.reset (synchronous in the core)
- core_start  out  1  to sha256.start
- core_num_chunks  out  2  to sha256.num_chunks
- core_str  out  1024  to sha256.str
- core_done  in  1  from sha256.done
- core_hash  in  256  from sha256.hash

Behaviour:
- Asynchronous reset: state IDLE; busy, found, exhausted, core_start = 0; core_reset = 1; found_nonce, found_hash, hashes_done, nonce, hash1 = 0.
- FSM states: IDLE, P1_PREP, P1_RUN, P2_PREP, P2_RUN, CHECK.
- Output decode: core_reset = 1 in IDLE, P1_PREP, P2_PREP, else 0. core_start = 1 only in P1_RUN, P2_RUN.
- The core's chunk counter only clears on reset, so every pass is preceded by exactly one core_reset cycle with start low.
- IDLE: on job_start && !abort, latch the inputs, set nonce = nonce_start, clear hashes_done, go to P1_PREP. job_start is ignored when not in IDLE.
- P1_PREP: 1 cycle, then P1_RUN.
- P1_RUN: core_num_chunks = 2; core_str = {hdr[639:32], bswap32(nonce), 1'b1, 319'b0, 64'd640}. On core_done: hash1 <= core_hash, go to P2_PREP.
- P2_PREP: 1 cycle, then P2_RUN.
- P2_RUN: core_num_chunks = 1; core_str = {hash1, 1'b1, 191'b0, 64'd256, 512'b0}. On core_done: hash2 <= core_hash, go to CHECK.
- CHECK (1 cycle):
  - val = byte-reverse of hash2; hashes_done += 1 (saturating).
  - If val <= target (unsigned 256-bit): found pulse, found_nonce <= nonce, found_hash <= val, go to IDLE.
  - Else if nonce == nonce_end: exhausted pulse, go to IDLE.
  - Else nonce <= nonce + 1 (mod 2^32, wraps FFFFFFFF -> 0), go to P1_PREP.
- Per-nonce latency = T1 + T2 + 3 cycles, where T1 and T2 are the core run lengths for 2 chunks and 1 chunk.
- abort in any non-IDLE state: go to IDLE next cycle, no found/exhausted pulse; found_* retain previous values; hashes_done frozen.
- abort together with job_start in IDLE: job not accepted.
- nonce_start == nonce_end: exactly one nonce is checked.
- A hit and nonce == nonce_end in the same CHECK: found only.
- busy = (state != IDLE).
- core_done is sampled only in the RUN states; stale done in other states is ignored.

Decomposition:
- sha2_pkg holds: state enum, PAD constants (len640, len256), bswap32 and bswap256 functions, HDR_W.
- One sub-module, sha256d_pad: purely combinational builder of core_str and core_num_chunks from (pass, header, nonce, hash1).
- FSM, counters and comparator live in sha256d_nonce_ctrl.

Test Plan:
- Genesis block. Bench instantiates the real sha256 (MAX_CHUNKS=2). header = 01000000 | 32 zero bytes | 3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a | 29ab5f49 | ffff001d | 00000000. nonce_start = 7c2bac1b, nonce_end = 7c2bac20, target = 00000000ffff0000...0. Required: found after hashes_done = 3; found_nonce = 7c2bac1d; found_hash = 000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f; busy low the next cycle.
- Same header, nonce_end = 7c2bac1c -> exhausted pulse, hashes_done = 2, found never asserted, found_* unchanged.
- Wrap: nonce_start = ffffffff, nonce_end = 00000001, target = 0 -> three CHECK cycles with nonces ffffffff, 0, 1, then exhausted, hashes_done = 3.
- target = all ones, any header -> found on the first nonce, hashes_done = 1. Check core_reset high exactly one cycle before each core_start rising edge.
- abort asserted during P2_RUN -> IDLE next cycle, core_start 0, no pulses. A following job_start runs the genesis case correctly, proving the core is re-initialised.
- Async reset asserted mid-P1_RUN between clock edges -> all outputs at reset values immediately. job_start during busy and job_start with abort are both ignored.
